// File: rtl/dmem_arbiter.sv
// Data memory port arbiter: core has fixed priority, DMA gets a
// forced grant after a bounded run of core wins while it waits.
module dmem_arbiter #(
  parameter int MP_DATA_WIDTH   = 32,
  parameter int MP_STARVE_LIMIT = 4
) (
  input  logic                     iclk,
  input  logic                     irst,
  input  logic                     icore_req,
  input  logic                     icore_wen,
  input  logic [31:0]              icore_addr,
  input  logic [1:0]               icore_be,
  input  logic [MP_DATA_WIDTH-1:0] icore_wdata,
  output logic                     ocore_ready,
  output logic [MP_DATA_WIDTH-1:0] ocore_rdata,
  output logic                     ocore_rvalid,
  input  logic                     idma_req,
  input  logic                     idma_wen,
  input  logic [31:0]              idma_addr,
  input  logic [1:0]               idma_be,
  input  logic [MP_DATA_WIDTH-1:0] idma_wdata,
  output logic                     odma_ready,
  output logic [MP_DATA_WIDTH-1:0] odma_rdata,
  output logic                     odma_rvalid,
  output logic [31:0]              omem_addr,
  output logic                     omem_wen,
  output logic [1:0]               omem_be,
  output logic [MP_DATA_WIDTH-1:0] omem_wdata,
  input  logic [MP_DATA_WIDTH-1:0] imem_rdata
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CORE = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;
  localparam logic [3:0] LIMIT    = 4'(MP_STARVE_LIMIT);

  logic [3:0]               starve_cnt_q, starve_cnt_d;
  logic                     force_dma_q, force_dma_d;
  logic [1:0]               rd_owner_q, rd_owner_d;
  logic [MP_DATA_WIDTH-1:0] core_rdata_q, core_rdata_d;
  logic [MP_DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;
  logic                     gnt_core, gnt_dma;

  // Grant: forced DMA first, then core, then DMA
  always_comb begin
    gnt_dma  = idma_req & (force_dma_q | ~icore_req);
    gnt_core = icore_req & ~gnt_dma;
  end

  assign ocore_ready = gnt_core;
  assign odma_ready  = gnt_dma;

  // Memory-side mux; writes are suppressed while in reset
  always_comb begin
    omem_addr  = '0;
    omem_wen   = 1'b0;
    omem_be    = '0;
    omem_wdata = '0;
    unique case (1'b1)
      gnt_core: begin
        omem_addr  = icore_addr;
        omem_wen   = icore_wen;
        omem_be    = icore_be;
        omem_wdata = icore_wdata;
      end
      gnt_dma: begin
        omem_addr  = idma_addr;
        omem_wen   = idma_wen;
        omem_be    = idma_be;
        omem_wdata = idma_wdata;
      end
      default: ;
    endcase
    if (!irst) omem_wen = 1'b0;
  end

  // Starvation limiter; a withdrawn DMA request loses its credit
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    force_dma_d  = force_dma_q;
    if (!idma_req || gnt_dma) begin
      starve_cnt_d = '0;
      force_dma_d  = 1'b0;
    end else if (gnt_core) begin
      if (starve_cnt_q + 4'd1 == LIMIT) begin
        starve_cnt_d = '0;
        force_dma_d  = 1'b1;
      end else begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  // Read return: remember who read, capture data for that owner only
  always_comb begin
    rd_owner_d = OWN_NONE;
    if (gnt_core && !icore_wen)
      rd_owner_d = OWN_CORE;
    else if (gnt_dma && !idma_wen)
      rd_owner_d = OWN_DMA;
    core_rdata_d = core_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    if (rd_owner_d == OWN_CORE) core_rdata_d = imem_rdata;
    if (rd_owner_d == OWN_DMA)  dma_rdata_d  = imem_rdata;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge iclk) begin
    if (!irst) begin
      starve_cnt_q <= '0;
      force_dma_q  <= 1'b0;
      rd_owner_q   <= OWN_NONE;
      core_rdata_q <= '0;
      dma_rdata_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      force_dma_q  <= force_dma_d;
      rd_owner_q   <= rd_owner_d;
      core_rdata_q <= core_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign ocore_rdata  = core_rdata_q;
  assign odma_rdata   = dma_rdata_q;
  assign ocore_rvalid = (rd_owner_q == OWN_CORE);
  assign odma_rvalid  = (rd_owner_q == OWN_DMA);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a read-return scoreboard
// and a behavioural data memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        irst;
  logic        icore_req, icore_wen;
  logic [31:0] icore_addr, icore_wdata;
  logic [1:0]  icore_be;
  logic        ocore_ready, ocore_rvalid;
  logic [31:0] ocore_rdata;
  logic        idma_req, idma_wen;
  logic [31:0] idma_addr, idma_wdata;
  logic [1:0]  idma_be;
  logic        odma_ready, odma_rvalid;
  logic [31:0] odma_rdata;
  logic [31:0] omem_addr, omem_wdata, imem_rdata;
  logic        omem_wen;
  logic [1:0]  omem_be;

  logic [31:0] mem [0:255];

  typedef struct {
    bit          dma;
    logic [31:0] d;
  } ret_t;
  ret_t sb[$];

  int total = 0;
  int passed = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[omem_addr[9:2]];

  always @(posedge clk)
    if (omem_wen) mem[omem_addr[9:2]] <= omem_wdata;

  dmem_arbiter #(
    .MP_DATA_WIDTH(32),
    .MP_STARVE_LIMIT(4)
  ) dut (
    .iclk(clk),
    .irst(irst),
    .icore_req(icore_req),
    .icore_wen(icore_wen),
    .icore_addr(icore_addr),
    .icore_be(icore_be),
    .icore_wdata(icore_wdata),
    .ocore_ready(ocore_ready),
    .ocore_rdata(ocore_rdata),
    .ocore_rvalid(ocore_rvalid),
    .idma_req(idma_req),
    .idma_wen(idma_wen),
    .idma_addr(idma_addr),
    .idma_be(idma_be),
    .idma_wdata(idma_wdata),
    .odma_ready(odma_ready),
    .odma_rdata(odma_rdata),
    .odma_rvalid(odma_rvalid),
    .omem_addr(omem_addr),
    .omem_wen(omem_wen),
    .omem_be(omem_be),
    .omem_wdata(omem_wdata),
    .imem_rdata(imem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic core(input logic r, w,
                      input logic [31:0] a, d);
    icore_req = r; icore_wen = w;
    icore_addr = a; icore_wdata = d;
  endtask

  task automatic dma(input logic r, w,
                     input logic [31:0] a, d);
    idma_req = r; idma_wen = w;
    idma_addr = a; idma_wdata = d;
  endtask

  // Checks the read return due now, then this cycle's grant,
  // and queues the return expected next cycle.
  task automatic step(input logic ec, ed,
                      input logic [31:0] crd, drd);
    ret_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dma) begin
        chk("dma_rvalid", {31'd0, odma_rvalid}, 32'd1);
        chk("dma_rdata", odma_rdata, e.d);
        chk("core_rvalid_idle", {31'd0, ocore_rvalid}, 32'd0);
      end else begin
        chk("core_rvalid", {31'd0, ocore_rvalid}, 32'd1);
        chk("core_rdata", ocore_rdata, e.d);
        chk("dma_rvalid_idle", {31'd0, odma_rvalid}, 32'd0);
      end
    end else begin
      chk("core_rvalid_none", {31'd0, ocore_rvalid}, 32'd0);
      chk("dma_rvalid_none", {31'd0, odma_rvalid}, 32'd0);
    end
    chk("core_ready", {31'd0, ocore_ready}, {31'd0, ec});
    chk("dma_ready", {31'd0, odma_ready}, {31'd0, ed});
    if (irst && ec && !icore_wen) begin
      e.dma = 1'b0; e.d = crd; sb.push_back(e);
    end
    if (irst && ed && !idma_wen) begin
      e.dma = 1'b1; e.d = drd; sb.push_back(e);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
    mem[8'h04] = 32'hDEAD_BEEF;
    irst = 1'b0;
    icore_be = 2'd2;
    idma_be = 2'd2;
    core(0, 0, 0, 0);
    dma(0, 0, 0, 0);

    // reset state
    nxt(); nxt();
    irst = 1'b1;
    #1;
    chk("rst_core_rdata", ocore_rdata, 32'd0);
    chk("rst_dma_rdata", odma_rdata, 32'd0);

    // idle
    step(0, 0, 0, 0);
    chk("idle_wen", {31'd0, omem_wen}, 32'd0);
    chk("idle_addr", omem_addr, 32'd0);
    nxt(); step(0, 0, 0, 0);

    // core-only read
    nxt(); core(1, 0, 32'h10, 0);
    step(1, 0, 32'hDEAD_BEEF, 0);
    chk("core_rd_addr", omem_addr, 32'h10);
    nxt(); core(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // DMA write then core read of the same word
    nxt(); dma(1, 1, 32'h20, 32'h1234_5678);
    step(0, 1, 0, 0);
    chk("dma_wr_wen", {31'd0, omem_wen}, 32'd1);
    nxt(); dma(0, 0, 0, 0); core(1, 0, 32'h20, 0);
    step(1, 0, 32'h1234_5678, 0);
    nxt(); core(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // contention: 4 core wins then one forced DMA, repeated
    nxt(); core(1, 0, 32'h30, 0); dma(1, 0, 32'h40, 0);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) nxt();
      if (c == 4 || c == 9)
        step(0, 1, 0, 32'hA000_0010);
      else
        step(1, 0, 32'hA000_000C, 0);
    end
    nxt(); core(0, 0, 0, 0); dma(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // credit loss: 3 wins, DMA drops, then 4 more wins needed
    for (int c = 0; c < 9; c++) begin
      nxt();
      core(1, 1, 32'h80, 32'hCAFE_F00D);
      dma(c != 3, 0, 32'h40, 0);
      if (c == 8) step(0, 1, 0, 32'hA000_0010);
      else        step(1, 0, 0, 0);
    end
    nxt(); core(1, 0, 32'h80, 0); dma(0, 0, 0, 0);
    step(1, 0, 32'hCAFE_F00D, 0);
    nxt(); core(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // reset during a granted read, then a write held in reset
    nxt(); core(1, 0, 32'h10, 0); irst = 1'b0;
    step(1, 0, 0, 0);
    nxt(); core(1, 1, 32'h10, 32'hBAD0_BAD0);
    step(1, 0, 0, 0);
    chk("rst_wen_blocked", {31'd0, omem_wen}, 32'd0);
    chk("rst_rdata_clr", ocore_rdata, 32'd0);
    chk("rst_dma_rdata_clr", odma_rdata, 32'd0);
    nxt(); irst = 1'b1; core(1, 0, 32'h10, 0);
    step(1, 0, 32'hDEAD_BEEF, 0);
    nxt(); core(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
